// File: rtl/i_demod_pkg.sv
// Shared definitions for the I-channel correlator/demodulator.
// Contents: sample, coefficient and accumulator widths, default mid-scale offset and level
// threshold, the 16-phase cosine table and the FSM state type.
package i_demod_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int COEF_W     = 8;
    localparam int ACC_W      = 20;
    localparam int IDX_W      = 4;
    localparam int N_PHASE    = 16;
    localparam int OFFSET_DEF = 100;
    localparam int THRESH_DEF = 36000;

    // round(127*cos(2*pi*n/16))
    localparam logic signed [COEF_W-1:0] COS_TAB [N_PHASE] = '{
        8'sd127,  8'sd117,  8'sd90,   8'sd49,   8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
       -8'sd127, -8'sd117, -8'sd90,  -8'sd49,   8'sd0,    8'sd49,   8'sd90,   8'sd117
    };

    typedef enum logic [0:0] {StIdle, StAcc} state_t;

endpackage

// File: rtl/i_cos_rom.sv
// Combinational cosine coefficient table.
// Ports: addr - symbol phase index (4 bits); coef - signed 8-bit coefficient for that phase.
module i_cos_rom
    import i_demod_pkg::*;
(
    input  logic [IDX_W-1:0]  addr,
    output logic [COEF_W-1:0] coef
);

    assign coef = COS_TAB[addr];

endmodule

// File: rtl/i_demod.sv
// I-channel symbol correlator: correlates 16 samples per symbol with a cosine and decides
// the sign. Two pipeline stages (operand register, multiply-accumulate) then an output register.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   sample_in      - unsigned 8-bit sample, accepted when sample_valid is high
//   sync           - marks the accepted sample as phase 0 of a symbol
//   corr_out       - signed 20-bit correlation of the last complete symbol
//   sym_out        - 1 when corr_out is negative
//   sym_valid      - one-cycle pulse on new corr_out/sym_out
//   sync_err       - one-cycle pulse when sync arrives mid-symbol
//   lvl_out        - (only with I_DEMOD_LVL_EN) 1 when |corr| >= THRESH
// Build option: define I_DEMOD_LVL_EN to add lvl_out and the magnitude compare.
module i_demod
    import i_demod_pkg::*;
#(
    parameter int OFFSET = OFFSET_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                sync,
    output logic [ACC_W-1:0]    corr_out,
    output logic                sym_out,
    output logic                sym_valid,
`ifdef I_DEMOD_LVL_EN
    output logic                lvl_out,
`endif
    output logic                sync_err
);

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           cur_idx;
    logic [COEF_W-1:0]          coef;
    logic signed [SAMPLE_W:0]   d_in;
    logic                       take;
    logic                       abort;

    // Stage 1 registers
    logic signed [SAMPLE_W:0]   d_q;
    logic signed [COEF_W-1:0]   c_q;
    logic                       s1_valid_q;
    logic                       s1_first_q;
    logic                       s1_last_q;

    // Stage 2 registers
    logic signed [SAMPLE_W+COEF_W:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       done_q;

    // In IDLE only a synced sample starts a symbol; in ACC every valid sample is taken.
    assign take    = sample_valid & (sync | (state_q == StAcc));
    assign abort   = sample_valid & sync & (state_q == StAcc) & (idx_q != '0);
    assign cur_idx = sync ? '0 : idx_q;
    assign d_in    = $signed({1'b0, sample_in}) - 9'(OFFSET);

    i_cos_rom u_rom (
        .addr (cur_idx),
        .coef (coef)
    );

    // FSM, phase index and stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            d_q        <= '0;
            c_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            s1_valid_q <= take;
            sync_err   <= abort;
            if (take) begin
                state_q    <= StAcc;
                idx_q      <= cur_idx + 4'd1;
                d_q        <= d_in;
                c_q        <= $signed(coef);
                s1_first_q <= (cur_idx == '0);
                s1_last_q  <= (cur_idx == 4'(N_PHASE - 1));
            end
        end
    end

    assign prod = 17'(d_q) * 17'(c_q);

`ifdef I_DEMOD_LVL_EN
    logic [ACC_W:0] mag;
    assign mag = acc_q[ACC_W-1] ? (ACC_W+1)'(0) - {acc_q[ACC_W-1], acc_q} : {1'b0, acc_q};
`endif

    // Stage 2 (multiply-accumulate) and output register. A phase-0 product replaces the
    // accumulator, so an aborted partial sum is discarded and back-to-back symbols need no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            done_q    <= 1'b0;
            corr_out  <= '0;
            sym_out   <= 1'b0;
            sym_valid <= 1'b0;
`ifdef I_DEMOD_LVL_EN
            lvl_out   <= 1'b0;
`endif
        end else begin
            done_q    <= s1_valid_q & s1_last_q;
            sym_valid <= done_q;
            if (s1_valid_q) begin
                acc_q <= (s1_first_q ? '0 : acc_q) + ACC_W'(prod);
            end
            if (done_q) begin
                corr_out <= acc_q;
                sym_out  <= acc_q[ACC_W-1];
`ifdef I_DEMOD_LVL_EN
                lvl_out  <= (mag >= (ACC_W+1)'(THRESH));
`endif
            end
        end
    end

endmodule

// File: tb/tb_i_demod.sv
// Self-checking bench for i_demod: directed symbol cases plus randomized traffic, all compared
// against a transaction-level model of the correlator.
module tb_i_demod;

    localparam int OFFSET = 100;
    localparam int THRESH = 36000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sync = 1'b0;
    logic [19:0] corr_out;
    logic        sym_out;
    logic        sym_valid;
    logic        sync_err;
`ifdef I_DEMOD_LVL_EN
    logic        lvl_out;
`endif

    always #5 clk = ~clk;

    i_demod #(
        .OFFSET (OFFSET),
        .THRESH (THRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sync         (sync),
        .corr_out     (corr_out),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
`ifdef I_DEMOD_LVL_EN
        .lvl_out      (lvl_out),
`endif
        .sync_err     (sync_err)
    );

    typedef struct {
        int due;
        int val;
    } ev_t;

    int  n_checks = 0;
    int  n_errors = 0;
    int  coef_tab [16];
    int  seq [16] = '{29, 35, 50, 73, 100, 127, 150, 165, 171, 165, 150, 127, 100, 73, 50, 35};

    // Model state
    int  cyc = 0;
    bit  m_acc;
    int  m_idx;
    int  m_sum;
    ev_t pend [$];
    int  m_corr;
    bit  m_sym, m_lvl, m_valid, m_err;
    int  valid_cycles [$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int wrap20(input int x);
        logic [19:0] t;
        t = x[19:0];
        return int'($signed(t));
    endfunction

    // One clock: drive inputs, advance the model by the same edge, check all outputs.
    task automatic step(input bit r, input bit v, input bit s, input int smp);
        ev_t ev;
        int  a;
        rst          = r;
        sample_valid = v;
        sync         = s;
        sample_in    = smp[7:0];
        @(posedge clk);
        cyc++;
        m_valid = 0;
        m_err   = 0;
        if (r) begin
            m_acc = 0; m_idx = 0; m_sum = 0; pend.delete();
            m_corr = 0; m_sym = 0; m_lvl = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ev      = pend.pop_front();
                m_valid = 1;
                m_corr  = ev.val;
                m_sym   = (ev.val < 0);
                a       = (ev.val < 0) ? -ev.val : ev.val;
                m_lvl   = (a >= THRESH);
            end
            if (v && (s || m_acc)) begin
                if (s) begin
                    if (m_acc && m_idx != 0) m_err = 1;
                    m_idx = 0;
                end
                if (m_idx == 0) m_sum = 0;
                m_acc = 1;
                m_sum += (smp - OFFSET) * coef_tab[m_idx];
                if (m_idx == 15) pend.push_back('{due: cyc + 2, val: wrap20(m_sum)});
                m_idx = (m_idx + 1) % 16;
            end
        end
        #1;
        check_eq("sym_valid", int'(sym_valid), int'(m_valid));
        check_eq("sync_err", int'(sync_err), int'(m_err));
        check_eq("corr_out", int'($signed(corr_out)), m_corr);
        check_eq("sym_out", int'(sym_out), int'(m_sym));
`ifdef I_DEMOD_LVL_EN
        check_eq("lvl_out", int'(lvl_out), int'(m_lvl));
`endif
        if (sym_valid) valid_cycles.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        real pi;
        real x;
        pi = 3.14159265358979;
        for (int n = 0; n < 16; n++) begin
            x = 127.0 * $cos(2.0 * pi * n / 16.0);
            coef_tab[n] = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
        end
        check_eq("rom_c3", coef_tab[3], 49);

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("rst_corr", int'(corr_out), 0);
        check_eq("rst_valid", int'(sym_valid), 0);
        idle(2);

        // Reference symbol
        for (int i = 0; i < 16; i++) step(0, 1, i == 0, seq[i]);
        step(0, 0, 0, 0);
        check_eq("ref_early", int'(sym_valid), 0);
        step(0, 0, 0, 0);
        check_eq("ref_valid", int'(sym_valid), 1);
        check_eq("ref_corr", int'($signed(corr_out)), -71746);
        check_eq("ref_sym", int'(sym_out), 1);
`ifdef I_DEMOD_LVL_EN
        check_eq("ref_lvl", int'(lvl_out), 1);
`endif
        idle(2);
        check_eq("hold_corr", int'($signed(corr_out)), -71746);

        // Mirrored symbol
        for (int i = 0; i < 16; i++) step(0, 1, i == 0, 200 - seq[i]);
        idle(2);
        check_eq("mir_corr", int'($signed(corr_out)), 71746);
        check_eq("mir_sym", int'(sym_out), 0);
`ifdef I_DEMOD_LVL_EN
        check_eq("mir_lvl", int'(lvl_out), 1);
`endif
        idle(1);

        // Mid-scale constant
        for (int i = 0; i < 16; i++) step(0, 1, i == 0, 100);
        idle(2);
        check_eq("zero_corr", int'($signed(corr_out)), 0);
        check_eq("zero_sym", int'(sym_out), 0);
        idle(1);

        // Back-to-back symbols, sync only on the first
        valid_cycles.delete();
        for (int i = 0; i < 32; i++) step(0, 1, i == 0, seq[i % 16]);
        idle(3);
        check_eq("b2b_count", valid_cycles.size(), 2);
        if (valid_cycles.size() == 2)
            check_eq("b2b_gap", valid_cycles[1] - valid_cycles[0], 16);

        // Resync at idx 7
        valid_cycles.delete();
        for (int i = 0; i < 7; i++) step(0, 1, i == 0, 200 - seq[i]);
        step(0, 1, 1, seq[0]);
        check_eq("resync_err", int'(sync_err), 1);
        for (int i = 1; i < 16; i++) step(0, 1, 0, seq[i]);
        idle(2);
        check_eq("resync_count", valid_cycles.size(), 1);
        check_eq("resync_corr", int'($signed(corr_out)), -71746);
        idle(1);

        // Reset at idx 10, then unsynced samples are ignored
        valid_cycles.delete();
        for (int i = 0; i < 10; i++) step(0, 1, i == 0, 200 - seq[i]);
        step(1, 1, 0, seq[10]);
        check_eq("rst10_corr", int'(corr_out), 0);
        check_eq("rst10_sym", int'(sym_out), 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, seq[i % 16]);
        idle(3);
        check_eq("rst10_none", valid_cycles.size(), 0);
        for (int i = 0; i < 16; i++) step(0, 1, i == 0, 200 - seq[i]);
        idle(2);
        check_eq("rst10_after", int'($signed(corr_out)), 71746);

        // Randomized traffic: gaps, stray syncs, rare resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 30) == 0,
                 int'($urandom % 256));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i_demod.md
I_DEMOD -- requirements
Module: i_demod

Interface
REQ-001 SHALL have parameter OFFSET, default 100, meaning the mid-scale value subtracted from every sample.
REQ-002 SHALL have parameter THRESH, default 36000, meaning the unsigned |corr| boundary between the inner and outer levels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port sample_in, input, 8 bits: unsigned I-channel sample, one per symbol phase.
REQ-006 SHALL have port sample_valid, input, 1 bit: when high, sample_in is accepted on that edge.
REQ-007 SHALL have port sync, input, 1 bit: qualified by sample_valid; marks the sample as phase 0 of a symbol.
REQ-008 SHALL have port corr_out, output, 20 bits: signed correlation of the last complete symbol.
REQ-009 SHALL have port sym_out, output, 1 bit: decision, 1 when corr_out < 0.
REQ-010 SHALL have port sym_valid, output, 1 bit: one-cycle pulse marking new corr_out and sym_out.
REQ-011 SHALL have port sync_err, output, 1 bit: one-cycle pulse when sync arrives mid-symbol.

Function
REQ-012 SHALL correlate 16 samples per symbol against ROM c[n] = round(127*cos(2*pi*n/16)): 127,117,90,49,0,-49,-90,-117,-127,-117,-90,-49,0,49,90,117.
REQ-013 SHALL form d = sample_in - OFFSET as 9-bit signed, product d*c[idx] as 17-bit signed, and the 20-bit signed accumulator without saturation.
REQ-014 SHALL implement FSM IDLE -> ACC on (sample_valid & sync), taking that sample as idx 0; samples without sync are ignored in IDLE.
REQ-015 SHALL, in ACC, advance 4-bit idx on each accepted sample, wrap 15->0, and continue into the next symbol without a new sync (free-running).
REQ-016 SHALL hold idx and the accumulator on cycles with sample_valid low; gaps do not break a symbol.
REQ-017 SHALL use a 2-stage pipeline: stage 1 registers d and c[idx]; stage 2 multiplies and accumulates.
REQ-018 SHALL pulse sym_valid exactly 2 cycles after the edge accepting idx 15, updating corr_out and sym_out on that same edge.
REQ-019 SHALL clear the accumulator for the next symbol, so that back-to-back symbols incur no bubble.
REQ-020 SHALL, on sync with idx != 0 in ACC, discard the partial sum, restart at idx 0 with this sample, pulse sync_err one cycle later, and omit sym_valid for the aborted symbol.
REQ-021 SHALL treat sync at idx 0 in ACC as a normal aligned start, with no error.
REQ-022 SHALL hold corr_out and sym_out between sym_valid pulses.

Reset
REQ-023 SHALL, on rst high at a clock edge, set the FSM to IDLE, idx to 0, the accumulator and pipeline registers to 0, corr_out to 0, sym_out to 0, sym_valid to 0, sync_err to 0, and lvl_out (if present) to 0.
REQ-024 SHALL give rst priority over sample_valid/sync; a reset mid-symbol drops the symbol with no sym_valid.

Configuration
REQ-025 SHALL, with I_DEMOD_LVL_EN defined, add output lvl_out (1 bit), registered with sym_valid, equal to 1 when |corr| >= THRESH (outer level of a 4-level I axis).
REQ-026 SHALL, without I_DEMOD_LVL_EN, omit the lvl_out port and the magnitude logic entirely; all other behaviour is identical.

Structure
REQ-027 SHALL place the cosine table, OFFSET default, widths (SAMPLE_W=8, COEF_W=8, ACC_W=20) and the FSM state enum in package i_demod_pkg.
REQ-028 SHALL implement the coefficient table as sub-module i_cos_rom (4-bit address in, 8-bit signed coefficient out, combinational).

Verification
REQ-029 SHALL cover: sync on first of 16 samples 29,35,50,73,100,127,150,165,171,165,150,127,100,73,50,35 -> corr_out = -71746, sym_out = 1, sym_valid 2 cycles after last sample.
REQ-030 SHALL cover: the same sequence with each sample replaced by 200 - s -> corr_out = +71746, sym_out = 0; with I_DEMOD_LVL_EN, lvl_out = 1 in both cases.
REQ-031 SHALL cover: 16 samples of constant 100 -> corr_out = 0, sym_out = 0, lvl_out = 0.
REQ-032 SHALL cover: two back-to-back symbols with sample_valid high continuously and sync only on the first -> two sym_valid pulses exactly 16 cycles apart.
REQ-033 SHALL cover: sync reasserted at idx 7 -> sync_err pulse, no sym_valid for the partial symbol, and a correct result 16 samples after the new sync.
REQ-034 SHALL cover: rst at idx 10 -> all outputs 0, FSM IDLE, and samples ignored until the next sync.
